// File: rtl/clk_rst_seq_arbiter_if.sv
// clk_rst_seq_arbiter_if: request/grant and staged clock/reset outputs of clk_rst_seq_arbiter.
interface clk_rst_seq_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int NUM_DOM = 3,
   parameter int CNT_W   = 16
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   logic [NUM_REQ-1:0]       req_valid_i;
   logic [NUM_REQ-1:0]       req_op_i;
   logic [NUM_REQ*CNT_W-1:0] req_len_i;
   logic [NUM_REQ-1:0]       req_ready_o;
   logic [PW-1:0]            grant_id_o;
   logic [NUM_DOM-1:0]       dom_rst_o;
   logic                     clk_gate_o;
   logic                     busy_o;
   logic                     done_o;
   modport master (output req_valid_i, req_op_i, req_len_i,
                   input  req_ready_o, grant_id_o, dom_rst_o, clk_gate_o, busy_o, done_o);
   modport slave  (input  req_valid_i, req_op_i, req_len_i,
                   output req_ready_o, grant_id_o, dom_rst_o, clk_gate_o, busy_o, done_o);
endinterface

// File: rtl/clk_rst_seq_arbiter.sv
// clk_rst_seq_arbiter: round-robin sequencer for staged reset release and clock gating.
// Define CLK_RST_SEQ_GATE_IN_RST_EN to also hold clk_gate_o high throughout ASSERT.
module clk_rst_seq_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_DOM   = 3,
   parameter int CNT_W     = 16,
   parameter int STAGE_GAP = 4,
   parameter bit RST_POL   = 1'b1
) (
   input logic                  tb_clk_o,
   input logic                  rst_enable,
   clk_rst_seq_arbiter_if.slave bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int IW = $clog2(NUM_DOM + 1);
   typedef enum logic [2:0] {IDLE, ASSERT, RELEASE, GATE, DONE} state_e;
   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d, gid_q, gid_d, gsel, cand;
   logic [CNT_W-1:0]   cnt_q, cnt_d, len_g;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NUM_DOM-1:0] dom_q, dom_d;
   logic [NUM_REQ-1:0] ready;
   logic               found;
   always_comb begin
      found = 1'b0;
      gsel  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && bus.req_valid_i[cand]) begin
            found = 1'b1;
            gsel  = cand;
         end
      end
      len_g = bus.req_len_i[int'(gsel)*CNT_W +: CNT_W];
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      ready   = '0;
      case (state_q)
         IDLE: if (found) begin
            ready[gsel] = 1'b1;
            gid_d       = gsel;
            ptr_d       = PW'((int'(gsel) + 1) % NUM_REQ);
            cnt_d       = len_g == '0 ? CNT_W'(1) : len_g;
            state_d     = bus.req_op_i[gsel] ? GATE : ASSERT;
            dom_d       = bus.req_op_i[gsel] ? dom_q : '1;
         end
         ASSERT: if (cnt_q == CNT_W'(1)) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(STAGE_GAP);
            idx_d   = '0;
         end else cnt_d = cnt_q - 1'b1;
         // one extra RELEASE cycle after the last domain clears before DONE
         RELEASE: if (idx_q == IW'(NUM_DOM)) state_d = DONE;
         else if (cnt_q == CNT_W'(1)) begin
            dom_d[idx_q] = 1'b0;
            idx_d        = idx_q + 1'b1;
            cnt_d        = CNT_W'(STAGE_GAP);
         end else cnt_d = cnt_q - 1'b1;
         GATE: if (cnt_q == CNT_W'(1)) state_d = DONE;
         else cnt_d = cnt_q - 1'b1;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge tb_clk_o or posedge rst_enable) begin
      if (rst_enable) begin
         state_q <= RELEASE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cnt_q   <= CNT_W'(STAGE_GAP);
         idx_q   <= '0;
         dom_q   <= '1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
      end
   end
   assign bus.req_ready_o = ready;
   assign bus.grant_id_o  = gid_q;
   assign bus.dom_rst_o   = RST_POL ? dom_q : ~dom_q;
`ifdef CLK_RST_SEQ_GATE_IN_RST_EN
   assign bus.clk_gate_o  = state_q == GATE || state_q == ASSERT;
`else
   assign bus.clk_gate_o  = state_q == GATE;
`endif
   assign bus.busy_o      = state_q != IDLE;
   assign bus.done_o      = state_q == DONE;
endmodule

// File: tb/tb_clk_rst_seq_arbiter.sv
// tb_clk_rst_seq_arbiter: scoreboard bench; stimulus queues expected grants and sequence profiles.
module tb_clk_rst_seq_arbiter;
   typedef struct {int tot; int ones; int c110; int c100; int gate;} exp_t;
   logic tb_clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   grant_q[$];
   exp_t done_q[$];
   clk_rst_seq_arbiter_if bus ();
   clk_rst_seq_arbiter dut (.tb_clk_o(tb_clk), .rst_enable(rst), .bus(bus.slave));
   always #5 tb_clk = ~tb_clk;
   task automatic check(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", n, a, e);
      end
   endtask
   function automatic int eff(input int l);
      return l == 0 ? 1 : l;
   endfunction
   function automatic exp_t e_pon();
      return exp_t'{13, 4, 4, 4, 0};
   endfunction
   function automatic exp_t e_rst(input int l);
`ifdef CLK_RST_SEQ_GATE_IN_RST_EN
      return exp_t'{eff(l) + 13, eff(l) + 4, 4, 4, eff(l)};
`else
      return exp_t'{eff(l) + 13, eff(l) + 4, 4, 4, 0};
`endif
   endfunction
   function automatic exp_t e_gate(input int l);
      return exp_t'{eff(l), 0, 0, 0, eff(l)};
   endfunction
   task automatic req(input int i, input bit op, input int len, input bit completes);
      grant_q.push_back(i);
      if (completes) done_q.push_back(op ? e_gate(len) : e_rst(len));
      bus.req_valid_i[i]          = 1'b1;
      bus.req_op_i[i]             = op;
      bus.req_len_i[i*16 +: 16]   = 16'(len);
   endtask
   task automatic serve(input int budget);
      logic [3:0] r;
      int n = 0;
      while (bus.req_valid_i != '0 && n < budget) begin
         @(negedge tb_clk);
         r = bus.req_ready_o;
         @(posedge tb_clk);
         #1 bus.req_valid_i = bus.req_valid_i & ~r;
         n++;
      end
      if (bus.req_valid_i != '0) check("serve_timeout", n, -1);
   endtask
   task automatic settle(input int budget);
      int n = 0;
      while ((grant_q.size() != 0 || done_q.size() != 0) && n < budget) begin
         @(negedge tb_clk);
         n++;
      end
      if (grant_q.size() != 0 || done_q.size() != 0) check("settle_timeout", n, -1);
      @(posedge tb_clk);
      #1;
   endtask
   task automatic check_rst_outputs(input string tag);
      check({tag, "_dom"}, int'(bus.dom_rst_o), 7);
      check({tag, "_gate"}, int'(bus.clk_gate_o), 0);
      check({tag, "_ready"}, int'(bus.req_ready_o), 0);
      check({tag, "_done"}, int'(bus.done_o), 0);
      check({tag, "_busy"}, int'(bus.busy_o), 1);
   endtask
   // monitor: per-sequence profile between a grant (or reset release) and done_o
   initial begin
      int tot = 0, ones = 0, c110 = 0, c100 = 0, gate = 0, exp_gid = 0, id;
      bit chk_gid = 0, chk_idle = 0;
      exp_t e;
      forever begin
         @(negedge tb_clk);
         if (rst) begin
            {tot, ones, c110, c100, gate} = '0;
            chk_gid  = 0;
            chk_idle = 0;
         end else begin
            if (chk_gid) check("grant_id", int'(bus.grant_id_o), exp_gid);
            if (chk_idle) check("busy_after_done", int'(bus.busy_o), 0);
            chk_gid  = 0;
            chk_idle = 0;
            if (bus.req_ready_o != '0) begin
               check("ready_onehot", $countones(bus.req_ready_o), 1);
               id = 0;
               for (int i = 0; i < 4; i++) if (bus.req_ready_o[i]) id = i;
               if (grant_q.size() == 0) check("unexpected_grant", id, -1);
               else begin
                  exp_gid = grant_q.pop_front();
                  check("grant", id, exp_gid);
                  chk_gid = 1;
               end
               {tot, ones, c110, c100, gate} = '0;
            end else if (bus.done_o) begin
               check("busy_at_done", int'(bus.busy_o), 1);
               if (done_q.size() == 0) check("unexpected_done", tot, -1);
               else begin
                  e = done_q.pop_front();
                  check("seq_cycles", tot, e.tot);
                  check("dom111_cycles", ones, e.ones);
                  check("dom110_cycles", c110, e.c110);
                  check("dom100_cycles", c100, e.c100);
                  check("gate_cycles", gate, e.gate);
               end
               {tot, ones, c110, c100, gate} = '0;
               chk_idle = 1;
            end else begin
               tot++;
               ones += int'(bus.dom_rst_o == 3'b111);
               c110 += int'(bus.dom_rst_o == 3'b110);
               c100 += int'(bus.dom_rst_o == 3'b100);
               gate += int'(bus.clk_gate_o);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end
   initial begin
      bus.req_valid_i = '0;
      bus.req_op_i    = '0;
      bus.req_len_i   = '0;
      repeat (5) @(posedge tb_clk);
      #1 check_rst_outputs("reset");
      check("reset_gid", int'(bus.grant_id_o), 0);
      done_q.push_back(e_pon());
      rst = 1'b0;
      settle(100);
      req(0, 1'b0, 10, 1'b1);
      serve(100);
      settle(100);
      req(2, 1'b1, 7, 1'b1);
      serve(100);
      settle(100);
      req(2, 1'b1, 0, 1'b1);
      serve(100);
      settle(100);
      req(3, 1'b1, 2, 1'b1);
      serve(100);
      settle(100);
      req(1, 1'b1, 3, 1'b1);
      req(3, 1'b0, 2, 1'b1);
      serve(200);
      settle(200);
      req(0, 1'b0, 1, 1'b1);
      req(3, 1'b1, 4, 1'b1);
      serve(200);
      settle(200);
      req(2, 1'b1, 7, 1'b0);
      begin
         int n = 0;
         logic got = 1'b0;
         while (!got && n < 50) begin
            @(negedge tb_clk);
            got = bus.req_ready_o[2];
            n++;
         end
         if (!got) check("abort_grant_timeout", n, -1);
      end
      @(posedge tb_clk);
      #1 bus.req_valid_i[2] = 1'b0;
      done_q.push_back(e_pon());
      req(1, 1'b0, 2, 1'b1);
      repeat (2) @(posedge tb_clk);
      #1 rst = 1'b1;
      #1 check_rst_outputs("abort");
      repeat (2) @(posedge tb_clk);
      #1 rst = 1'b0;
      serve(200);
      settle(200);
      repeat (3) @(negedge tb_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
